// File: rtl/div_seq_ctrl_if.sv
// Issue-side and CDB-side handshake bundle for the divider sequencing controller.
// The master modport is the reservation station / CDB side, the slave modport is the controller.
interface div_seq_ctrl_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
);
    logic             iss_valid;
    logic             iss_ready;
    logic [1:0]       iss_op;
    logic [WIDTH-1:0] iss_rs1;
    logic [WIDTH-1:0] iss_rs2;
    logic [TAG_W-1:0] iss_tag;

    logic             cdb_valid;
    logic             cdb_ready;
    logic [TAG_W-1:0] cdb_tag;
    logic [WIDTH-1:0] cdb_data;

    modport master (
        output iss_valid, iss_op, iss_rs1, iss_rs2, iss_tag, cdb_ready,
        input  iss_ready, cdb_valid, cdb_tag, cdb_data
    );

    modport slave (
        input  iss_valid, iss_op, iss_rs1, iss_rs2, iss_tag, cdb_ready,
        output iss_ready, cdb_valid, cdb_tag, cdb_data
    );
endinterface

// File: rtl/div_seq_ctrl.sv
// Sequencing controller wrapping an unsigned multicycle divider core for RV32M
// DIV/DIVU/REM/REMU: sign handling, zero/overflow bypass, fixed-latency capture, flush.
module div_seq_ctrl #(
    parameter int WIDTH   = 32,
    parameter int NUM_CYC = 32,
    parameter int TAG_W   = 5
) (
    input  logic             inst_clk,
    input  logic             inst_rst_n,
    input  logic             flush,
    div_seq_ctrl_if.slave    bus,
    output logic             div_start,
    output logic             div_hold,
    output logic [WIDTH-1:0] div_a,
    output logic [WIDTH-1:0] div_b,
    input  logic             div_complete,
    input  logic [WIDTH-1:0] div_quotient,
    input  logic [WIDTH-1:0] div_remainder
);

    localparam int CNT_W = (NUM_CYC > 1) ? $clog2(NUM_CYC) : 1;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY, S_DONE} state_t;

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_is_rem;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] r_div_a;
    logic [WIDTH-1:0] r_div_b;
    logic [TAG_W-1:0] r_cdb_tag;
    logic [WIDTH-1:0] r_cdb_data;

    logic             w_signed, w_rs1_neg, w_rs2_neg;
    logic             w_div_zero, w_ovf, w_bypass;
    logic             w_accept, w_capture;
    logic [WIDTH-1:0] w_abs_a, w_abs_b, w_bypass_data;
    logic [WIDTH-1:0] w_q_fix, w_r_fix, w_result;

    // Operand decode for the op currently offered on the issue port.
    assign w_signed   = ~bus.iss_op[0];
    assign w_rs1_neg  = w_signed & bus.iss_rs1[WIDTH-1];
    assign w_rs2_neg  = w_signed & bus.iss_rs2[WIDTH-1];
    assign w_abs_a    = w_rs1_neg ? -bus.iss_rs1 : bus.iss_rs1;
    assign w_abs_b    = w_rs2_neg ? -bus.iss_rs2 : bus.iss_rs2;
    assign w_div_zero = (bus.iss_rs2 == '0);
    assign w_ovf      = w_signed & (bus.iss_rs1 == MIN_NEG) & (bus.iss_rs2 == '1);
    assign w_bypass   = w_div_zero | w_ovf;
    assign w_bypass_data = bus.iss_op[1] ? (w_div_zero ? bus.iss_rs1 : '0)
                                         : (w_div_zero ? '1 : MIN_NEG);

    assign w_accept  = (r_state == S_IDLE) & bus.iss_valid & ~flush;
    assign w_capture = (r_state == S_BUSY) & (r_cnt == '0) & div_complete & ~flush;

    assign w_q_fix  = r_neg_q ? -div_quotient  : div_quotient;
    assign w_r_fix  = r_neg_r ? -div_remainder : div_remainder;
    assign w_result = r_is_rem ? w_r_fix : w_q_fix;

    always_ff @(posedge inst_clk or negedge inst_rst_n) begin
        if (!inst_rst_n) r_state <= S_IDLE;
        else             r_state <= w_state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt   = r_state;
        div_start     = 1'b0;
        bus.iss_ready = 1'b0;
        bus.cdb_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.iss_ready = 1'b1;
                if (bus.iss_valid) w_state_nxt = w_bypass ? S_DONE : S_START;
            end
            S_START: begin
                div_start   = 1'b1;
                w_state_nxt = S_BUSY;
            end
            S_BUSY: begin
                if (r_cnt == '0 && div_complete) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                bus.cdb_valid = 1'b1;
                if (bus.cdb_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (flush) w_state_nxt = S_IDLE;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge inst_clk or negedge inst_rst_n) begin
        if (!inst_rst_n) begin
            r_cnt      <= '0;
            r_is_rem   <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_div_a    <= '0;
            r_div_b    <= '0;
            r_cdb_tag  <= '0;
            r_cdb_data <= '0;
        end else begin
            if (w_accept) begin
                r_is_rem  <= bus.iss_op[1];
                r_neg_q   <= w_rs1_neg ^ w_rs2_neg;
                r_neg_r   <= w_rs1_neg;
                r_div_a   <= w_abs_a;
                r_div_b   <= w_abs_b;
                r_cdb_tag <= bus.iss_tag;
                if (w_bypass) r_cdb_data <= w_bypass_data;
            end
            if (w_capture) r_cdb_data <= w_result;

            if (flush)                             r_cnt <= '0;
            else if (r_state == S_START)           r_cnt <= CNT_W'(NUM_CYC - 1);
            else if (r_state == S_BUSY && r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign div_hold     = 1'b0;
    assign div_a        = r_div_a;
    assign div_b        = r_div_b;
    assign bus.cdb_tag  = r_cdb_tag;
    assign bus.cdb_data = r_cdb_data;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Self-checking bench for div_seq_ctrl: behavioural divider core, RV32M reference
// model, directed corner cases and randomized ops with CDB back-pressure.
module tb_div_seq_ctrl;

    localparam int WIDTH   = 32;
    localparam int NUM_CYC = 32;
    localparam int TAG_W   = 5;
    localparam logic [31:0] MIN_NEG = 32'h8000_0000;

    logic inst_clk = 1'b0;
    logic inst_rst_n = 1'b0;
    logic flush = 1'b0;

    logic             div_start, div_hold;
    logic [WIDTH-1:0] div_a, div_b;
    logic             core_complete;
    logic [WIDTH-1:0] core_q, core_r;

    int n_vec = 0;
    int n_err = 0;
    int start_cnt = 0;

    div_seq_ctrl_if #(.WIDTH(WIDTH), .TAG_W(TAG_W)) bus ();

    div_seq_ctrl #(.WIDTH(WIDTH), .NUM_CYC(NUM_CYC), .TAG_W(TAG_W)) dut (
        .inst_clk      (inst_clk),
        .inst_rst_n    (inst_rst_n),
        .flush         (flush),
        .bus           (bus),
        .div_start     (div_start),
        .div_hold      (div_hold),
        .div_a         (div_a),
        .div_b         (div_b),
        .div_complete  (core_complete),
        .div_quotient  (core_q),
        .div_remainder (core_r)
    );

    always #5 inst_clk = ~inst_clk;

    // Behavioural stand-in for the core: complete rises NUM_CYC cycles after the
    // start edge and stays high; results are formed from the live div_a/div_b, so
    // any operand instability shows up as wrong data. "glitch" raises a spurious
    // early complete carrying garbage, which the controller must ignore.
    int core_cnt;
    logic core_done;
    bit glitch = 1'b0;

    always @(posedge inst_clk or negedge inst_rst_n) begin
        if (!inst_rst_n) begin
            core_cnt  <= 0;
            core_done <= 1'b0;
        end else if (div_start) begin
            core_cnt  <= NUM_CYC - 1;
            core_done <= 1'b0;
        end else if (core_cnt != 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1) core_done <= 1'b1;
        end
    end

    always @(posedge inst_clk) if (inst_rst_n && div_start) start_cnt++;

    assign core_complete = core_done | (glitch && core_cnt >= 5 && core_cnt <= 10);
    assign core_q = core_done ? ((div_b == 0) ? '1 : div_a / div_b) : 32'hBAD0_BAD0;
    assign core_r = core_done ? ((div_b == 0) ? div_a : div_a % div_b) : 32'hBAD1_BAD1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // RV32M semantics from plain signed/unsigned arithmetic.
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        case (op)
            2'b00: if (b == 0) return '1;
                   else if (a == MIN_NEG && b == '1) return MIN_NEG;
                   else return 32'(sa / sb);
            2'b01: return (b == 0) ? '1 : a / b;
            2'b10: if (b == 0) return a;
                   else if (a == MIN_NEG && b == '1) return '0;
                   else return 32'(sa % sb);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_bypass(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        return (b == 0) || (!op[0] && a == MIN_NEG && b == '1);
    endfunction

    // Issue one op, wait for its result, apply `hold` cycles of back-pressure, retire it.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, input int hold);
        logic [31:0] exp_data, data0;
        int exp_lat, lat, starts0;
        bit seen, bp;
        exp_data = ref_result(op, a, b);
        bp       = is_bypass(op, a, b);
        exp_lat  = bp ? 1 : NUM_CYC + 2;

        @(negedge inst_clk);
        check("iss_ready_idle", 32'(bus.iss_ready), 32'd1);
        bus.iss_valid = 1'b1;
        bus.iss_op    = op;
        bus.iss_rs1   = a;
        bus.iss_rs2   = b;
        bus.iss_tag   = tag;
        bus.cdb_ready = (hold == 0);
        starts0 = start_cnt;
        @(posedge inst_clk);

        lat = 0;
        seen = 0;
        while (lat < 200 && !seen) begin
            @(negedge inst_clk);
            lat++;
            if (lat == 1) begin
                bus.iss_valid = 1'b0;
                check("iss_ready_busy", 32'(bus.iss_ready), 32'd0);
            end
            if (bus.cdb_valid) seen = 1;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        if (!seen) return;
        check("cdb_tag", 32'(bus.cdb_tag), 32'(tag));
        check("cdb_data", bus.cdb_data, exp_data);
        check("start_pulses", 32'(start_cnt - starts0), bp ? 32'd0 : 32'd1);
        data0 = bus.cdb_data;

        for (int i = 1; i < hold; i++) begin
            @(negedge inst_clk);
            check("hold_valid", 32'(bus.cdb_valid), 32'd1);
            check("hold_tag", 32'(bus.cdb_tag), 32'(tag));
            check("hold_data", bus.cdb_data, data0);
            check("hold_iss_ready", 32'(bus.iss_ready), 32'd0);
        end
        bus.cdb_ready = 1'b1;
        @(negedge inst_clk);
        check("retired_valid", 32'(bus.cdb_valid), 32'd0);
        check("retired_ready", 32'(bus.iss_ready), 32'd1);
    endtask

    initial begin
        logic [1:0]  op;
        logic [31:0] a, b;

        bus.iss_valid = 1'b0;
        bus.iss_op    = '0;
        bus.iss_rs1   = '0;
        bus.iss_rs2   = '0;
        bus.iss_tag   = '0;
        bus.cdb_ready = 1'b1;

        // Reset values.
        #12;
        check("rst_cdb_valid", 32'(bus.cdb_valid), 32'd0);
        check("rst_div_start", 32'(div_start), 32'd0);
        check("rst_div_a", div_a, 32'd0);
        check("rst_div_b", div_b, 32'd0);
        check("rst_cdb_tag", 32'(bus.cdb_tag), 32'd0);
        check("rst_cdb_data", bus.cdb_data, 32'd0);
        @(negedge inst_clk);
        inst_rst_n = 1'b1;
        @(negedge inst_clk);
        check("post_rst_iss_ready", 32'(bus.iss_ready), 32'd1);
        check("div_hold", 32'(div_hold), 32'd0);

        // Directed cases.
        run_op(2'b01, 32'd100, 32'd7, 5'd3, 0);
        run_op(2'b11, 32'd100, 32'd7, 5'd4, 0);
        run_op(2'b00, 32'hFFFF_FF9C, 32'd7, 5'd5, 0);
        run_op(2'b10, 32'hFFFF_FF9C, 32'd7, 5'd6, 0);
        run_op(2'b10, 32'd100, 32'hFFFF_FFF9, 5'd7, 0);
        run_op(2'b00, 32'd5, 32'd0, 5'd8, 0);
        run_op(2'b11, 32'd5, 32'd0, 5'd9, 0);
        run_op(2'b00, MIN_NEG, 32'hFFFF_FFFF, 5'd10, 0);
        run_op(2'b10, MIN_NEG, 32'hFFFF_FFFF, 5'd11, 0);
        run_op(2'b01, MIN_NEG, 32'hFFFF_FFFF, 5'd12, 0);
        run_op(2'b00, 32'd1000, 32'd9, 5'd13, 5);
        glitch = 1'b1;
        run_op(2'b11, 32'd12345, 32'd100, 5'd14, 0);
        glitch = 1'b0;

        // Flush in the 10th BUSY cycle, then an immediate fresh op.
        @(negedge inst_clk);
        bus.iss_valid = 1'b1;
        bus.iss_op    = 2'b01;
        bus.iss_rs1   = 32'd1000;
        bus.iss_rs2   = 32'd3;
        bus.iss_tag   = 5'd20;
        @(posedge inst_clk);
        for (int k = 1; k <= 11; k++) begin
            @(negedge inst_clk);
            bus.iss_valid = 1'b0;
        end
        flush = 1'b1;
        @(negedge inst_clk);
        flush = 1'b0;
        check("flush_cdb_valid", 32'(bus.cdb_valid), 32'd0);
        check("flush_iss_ready", 32'(bus.iss_ready), 32'd1);
        run_op(2'b01, 32'd9, 32'd3, 5'd21, 0);

        // Async reset while a result is waiting on the CDB.
        @(negedge inst_clk);
        bus.iss_valid = 1'b1;
        bus.iss_op    = 2'b00;
        bus.iss_rs1   = 32'd5;
        bus.iss_rs2   = 32'd0;
        bus.iss_tag   = 5'd17;
        bus.cdb_ready = 1'b0;
        @(posedge inst_clk);
        @(negedge inst_clk);
        bus.iss_valid = 1'b0;
        check("pre_rst_valid", 32'(bus.cdb_valid), 32'd1);
        inst_rst_n = 1'b0;
        #1;
        check("arst_cdb_valid", 32'(bus.cdb_valid), 32'd0);
        check("arst_cdb_data", bus.cdb_data, 32'd0);
        check("arst_cdb_tag", 32'(bus.cdb_tag), 32'd0);
        check("arst_div_a", div_a, 32'd0);
        @(negedge inst_clk);
        inst_rst_n = 1'b1;
        bus.cdb_ready = 1'b1;

        // Randomized ops against the reference model.
        for (int n = 0; n < 40; n++) begin
            op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0: begin a = $urandom; b = $urandom; end
                1: begin a = $urandom_range(0, 1000); b = $urandom_range(1, 20); end
                2: begin a = $urandom; b = 32'd0; end
                3: begin a = MIN_NEG; b = 32'hFFFF_FFFF; end
                4: begin a = -$urandom_range(1, 5000); b = $urandom_range(0, 1) ? 32'(-$urandom_range(1, 50)) : 32'($urandom_range(1, 50)); end
                default: begin a = $urandom_range(0, 1) ? 32'd0 : $urandom; b = 32'd1; end
            endcase
            glitch = ($urandom_range(0, 3) == 0);
            run_op(op, a, b, 5'($urandom), $urandom_range(0, 3));
        end
        glitch = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/div_seq_ctrl.md
Name: div_seq_ctrl

Overview:
- Sequencing controller for the unsigned multicycle divider core (DW_div_seq configured with tc_mode=0, input_mode=0, output_mode=0, rst_mode=0).
- Executes RV32M DIV/DIVU/REM/REMU for the OoO functional-unit slot.
- Accepts one op from the reservation station, does sign pre/post-processing and divide-by-zero/overflow bypass, and holds core operands stable for the whole operation.
- Returns the result with its ROB tag on a valid/ready CDB port and supports pipeline flush.

Parameters:
- WIDTH, 32, operand/result width.
- NUM_CYC, 32, core latency in cycles; must equal the core's num_cyc.
- TAG_W, 5, ROB tag width.

Ports:
- inst_clk  in  1  clock
- inst_rst_n  in  1  asynchronous active-low reset
- flush  in  1  kill any in-flight op
- iss_valid  in  1  op offered
- iss_ready  out  1  controller can accept
- iss_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
- iss_rs1  in  WIDTH  dividend
- iss_rs2  in  WIDTH  divisor
- iss_tag  in  TAG_W  ROB tag
- div_start  out  1  start pulse to core
- div_hold  out  1  tied 0
- div_a  out  WIDTH  unsigned dividend to core
- div_b  out  WIDTH  unsigned divisor to core
- div_complete  in  1  core complete
- div_quotient  in  WIDTH  core quotient
- div_remainder  in  WIDTH  core remainder
- cdb_valid  out  1  result valid
- cdb_ready  in  1  CDB accepts
- cdb_tag  out  TAG_W  result tag
- cdb_data  out  WIDTH  result

Behaviour:
- Reset (async, inst_rst_n=0):
  - State IDLE.
  - div_start, cdb_valid = 0; iss_ready = 1 once reset is released.
  - div_a, div_b, cdb_tag, cdb_data = 0.
  - Counter = 0.
- States: IDLE, START, BUSY, DONE. iss_ready = 1 only in IDLE.
- IDLE, when iss_valid & iss_ready:
  - Latch op, tag, sign flags, and abs operands. Signed ops take two's-complement abs of a negative input; DIVU/REMU pass operands through.
  - Divide-by-zero (rs2 = 0): go to DONE with quotient = all ones, remainder = rs1. Core is not started.
  - Signed overflow (DIV/REM, rs1 = 0x80000000, rs2 = 0xFFFFFFFF): go to DONE with quotient = 0x80000000, remainder = 0. Core is not started.
  - Otherwise: go to START.
- START (1 cycle):
  - div_start = 1; div_a/div_b already hold the registered abs operands.
  - Load counter = NUM_CYC - 1; go to BUSY.
- BUSY:
  - Decrement counter toward 0.
  - When counter = 0 and div_complete = 1: capture results and go to DONE. This gives a fixed NUM_CYC cycles from the start pulse to capture.
  - div_complete seen while counter != 0 is ignored.
- Post-processing at capture:
  - Signed quotient is negated if the dividend and divisor signs differ.
  - Signed remainder is negated if the dividend is negative.
  - cdb_data = quotient for DIV/DIVU, remainder for REM/REMU.
- DONE:
  - cdb_valid = 1; cdb_tag/cdb_data are stable while cdb_valid & !cdb_ready.
  - On cdb_ready, go to IDLE.
  - No new issue is accepted in the same cycle (single-entry unit).
- Latency:
  - Issue accepted at cycle T → cdb_valid at T+NUM_CYC+2 (T+34 with defaults).
  - Bypass case → cdb_valid at T+1.
- div_a/div_b change only on issue acceptance and stay stable START through DONE (required by input_mode=0).
- Flush (any state, synchronous):
  - Next state IDLE; cdb_valid drops the next cycle; counter cleared.
  - The abandoned core op is left running and is overwritten by the next div_start (the core restarts on start).
  - Flush has priority over issue acceptance and over cdb_ready in the same cycle.
  - Flush in START suppresses nothing already driven; the core run started that cycle is simply ignored.
- Async reset mid-operation returns all outputs to reset values immediately.

Test Plan:
- DIVU 100/7, tag 3, cdb_ready=1 → cdb_valid at T+34, tag 3, data 14; REMU same operands → data 2.
- DIV 0xFFFFFF9C (-100) / 7 → data 0xFFFFFFF2 (-14); REM same operands → 0xFFFFFFFE (-2); REM 100 / -7 → 2.
- DIV 5/0 → 0xFFFFFFFF at T+1; REMU 5/0 → 5 at T+1; div_start never asserted.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 at T+1; REM same operands → 0; div_start never asserted.
- cdb_ready held 0 for 5 cycles after the result → cdb_valid, tag, and data stable throughout; iss_ready stays 0; accepted on the first cycle cdb_ready=1.
- Flush at the 10th BUSY cycle → IDLE next cycle, no cdb_valid. A new DIVU 9/3 issued immediately afterwards returns 3 after the full latency, unaffected by the abandoned op.
